// File: rtl/operand_pair_loader_if.sv
// Byte-stream input and operand-pair output handshake bundle for operand_pair_loader.
interface operand_pair_loader_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             op_sel;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, a_out, b_out, op_sel, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, a_out, b_out, op_sel, out_valid
  );
endinterface

// File: rtl/operand_pair_loader.sv
// Assembles operand pair (A, B) from a byte stream and presents it to the XOR/AND combiner.
// Optional B-wait timeout is built only when OPLOAD_TIMEOUT_EN is defined.
//
// state   | meaning
// LOAD_A  | waiting for operand A byte
// LOAD_B  | A captured, waiting for operand B byte
// PRESENT | pair valid on outputs, waiting for combiner to take it
module operand_pair_loader #(
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  operand_pair_loader_if.slave bus,
  output logic [7:0]           pair_cnt,
  output logic                 err_to
);

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       pair_cnt_q, pair_cnt_d;
  logic             in_ready;
  logic             accept;
  logic             xfer;
  logic             timeout;

  assign in_ready = (state_q != PRESENT);
  assign accept   = bus.in_valid && in_ready;
  assign xfer     = out_valid_q && bus.out_ready;

`ifdef OPLOAD_TIMEOUT_EN
  logic [7:0] to_cnt_q, to_cnt_d;
  logic       err_to_q, err_to_d;

  // B arriving on the limit cycle wins, so the accept term masks the timeout.
  assign timeout = (state_q == LOAD_B) && !accept &&
                   (to_cnt_q == 8'(TIMEOUT_CYCLES - 1));

  always_comb begin
    to_cnt_d = 8'd0;
    err_to_d = 1'b0;
    if (!clear) begin
      if (timeout) begin
        err_to_d = 1'b1;
      end else if (state_q == LOAD_B && !accept) begin
        to_cnt_d = to_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= 8'd0;
      err_to_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_to_q <= err_to_d;
    end
  end

  assign err_to = err_to_q;
`else
  wire [7:0] unused_timeout = 8'(TIMEOUT_CYCLES);

  assign timeout = 1'b0;
  assign err_to  = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    out_valid_d = out_valid_q;
    pair_cnt_d  = pair_cnt_q;
    if (clear) begin
      state_d     = LOAD_A;
      out_valid_d = 1'b0;
    end else if (timeout) begin
      state_d = LOAD_A;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (accept) begin
            a_d     = bus.in_data;
            state_d = LOAD_B;
          end
        end
        LOAD_B: begin
          if (accept) begin
            b_d         = bus.in_data;
            out_valid_d = 1'b1;
            state_d     = PRESENT;
          end
        end
        PRESENT: begin
          if (xfer) begin
            out_valid_d = 1'b0;
            pair_cnt_d  = pair_cnt_q + 8'd1;
            state_d     = LOAD_A;
          end
        end
        default: begin
          state_d     = LOAD_A;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD_A;
      a_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
      pair_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_valid_q <= out_valid_d;
      pair_cnt_q  <= pair_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.a_out     = a_q;
  assign bus.b_out     = b_q;
  assign bus.op_sel    = a_q[WIDTH-1];
  assign bus.out_valid = out_valid_q;
  assign pair_cnt      = pair_cnt_q;

endmodule
